// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline hazard controller for the 5-stage MIPS core. It sits beside the
// ID-stage control unit and drives that unit's inStall input
// (1 = normal decode, 0 = force a bubble with all-zero controls).
//
// The unit resolves three hazard sources, highest priority first:
//   - a taken branch resolved in MEM, which flushes IF/ID, ID/EX and EX/MEM
//   - a load-use dependency between ID and ID/EX, which freezes PC and IF/ID
//     and inserts LOAD_STALL_CYCLES bubbles
//   - a jump decoded in ID, which discards the fall-through fetch in IF/ID
//
// Debug statistics: two saturating counters, one for bubble cycles and one
// for cycles with any flush asserted.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles per load-use hazard (>= 1)
//   COUNT_W            width of the statistics counters
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high
//   idOpcode        in   opcode of the instruction in ID
//   idRs, idRt      in   source register fields in ID
//   idExMemRead     in   MemRead of the instruction in ID/EX
//   idExRt          in   destination rt of the instruction in ID/EX
//   idJump          in   J/JAL decoded in ID
//   memBranchTaken  in   branch in MEM is taken
//   outStall        out  to control unit inStall; 0 = insert bubble
//   pcWrite         out  PC update enable
//   ifIdWrite       out  IF/ID write enable
//   ifIdFlush       out  clear IF/ID to NOP at next edge
//   idExFlush       out  clear ID/EX controls at next edge
//   exMemFlush      out  clear EX/MEM controls at next edge
//   stallCycles     out  cycles with outStall = 0, saturating
//   flushEvents     out  cycles with any flush asserted, saturating
//
// State table
//   state | meaning
//   RUN   | normal flow; hazards are detected and resolved this cycle
//   HOLD  | extra load-use bubbles after the hazard cycle (slow data memory)
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int COUNT_W           = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         idOpcode,
  input  logic [4:0]         idRs,
  input  logic [4:0]         idRt,
  input  logic               idExMemRead,
  input  logic [4:0]         idExRt,
  input  logic               idJump,
  input  logic               memBranchTaken,
  output logic               outStall,
  output logic               pcWrite,
  output logic               ifIdWrite,
  output logic               ifIdFlush,
  output logic               idExFlush,
  output logic               exMemFlush,
  output logic [COUNT_W-1:0] stallCycles,
  output logic [COUNT_W-1:0] flushEvents
);

  localparam int HW = $clog2(LOAD_STALL_CYCLES) + 1;
  // Hazard cycle itself is the first bubble, HOLD supplies the remainder.
  localparam logic [HW-1:0] HOLD_INIT = HW'(LOAD_STALL_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          id_uses_rt;
  logic          load_use;
  logic          any_flush;

  // Opcodes whose rt field is a source operand: R-type, BEQ, BNE, SB, SH, SW.
  always_comb begin
    id_uses_rt = (idOpcode == 6'd0)  || (idOpcode == 6'd4)  ||
                 (idOpcode == 6'd5)  || (idOpcode == 6'd40) ||
                 (idOpcode == 6'd41) || (idOpcode == 6'd43);
    load_use   = idExMemRead && (idExRt != 5'd0) &&
                 ((idExRt == idRs) || (id_uses_rt && (idExRt == idRt)));
  end

  always_comb begin
    outStall     = 1'b1;
    pcWrite      = 1'b1;
    ifIdWrite    = 1'b1;
    ifIdFlush    = 1'b0;
    idExFlush    = 1'b0;
    exMemFlush   = 1'b0;
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;

    // While in reset the outputs stay at their pass-through defaults.
    if (!reset) begin
      case (state)
        RUN: begin
          if (memBranchTaken) begin
            // Everything younger than the branch is on the wrong path.
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            exMemFlush = 1'b1;
          end else if (load_use) begin
            // A coincident jump is picked up again once ID advances.
            outStall  = 1'b0;
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt    = HOLD;
              hold_cnt_nxt = HOLD_INIT;
            end
          end else if (idJump) begin
            ifIdFlush = 1'b1;
          end
        end

        HOLD: begin
          if (memBranchTaken) begin
            // The stalled load-use pair is itself being squashed.
            ifIdFlush    = 1'b1;
            idExFlush    = 1'b1;
            exMemFlush   = 1'b1;
            state_nxt    = RUN;
            hold_cnt_nxt = '0;
          end else begin
            outStall     = 1'b0;
            pcWrite      = 1'b0;
            ifIdWrite    = 1'b0;
            hold_cnt_nxt = hold_cnt - HW'(1);
            if (hold_cnt == HOLD_LAST) begin
              state_nxt = RUN;
            end
          end
        end

        default: begin
          state_nxt    = RUN;
          hold_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign any_flush = ifIdFlush | idExFlush | exMemFlush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      hold_cnt    <= '0;
      stallCycles <= '0;
      flushEvents <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      if (!outStall && (stallCycles != CNT_MAX)) begin
        stallCycles <= stallCycles + COUNT_W'(1);
      end
      if (any_flush && (flushEvents != CNT_MAX)) begin
        flushEvents <= flushEvents + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: single-bubble configuration, 16-bit counters.
  logic        reset_a;
  logic [5:0]  op_a;
  logic [4:0]  rs_a, rt_a, exrt_a;
  logic        memrd_a, jmp_a, br_a;
  logic        stall_a, pcw_a, ifidw_a, iff_a, idf_a, exf_a;
  logic [15:0] scnt_a, fcnt_a;

  // Instance B: three-bubble configuration, 2-bit counters.
  logic        reset_b;
  logic [5:0]  op_b;
  logic [4:0]  rs_b, rt_b, exrt_b;
  logic        memrd_b, jmp_b, br_b;
  logic        stall_b, pcw_b, ifidw_b, iff_b, idf_b, exf_b;
  logic [1:0]  scnt_b, fcnt_b;

  hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .COUNT_W(16)) u_a (
    .clk(clk), .reset(reset_a), .idOpcode(op_a), .idRs(rs_a), .idRt(rt_a),
    .idExMemRead(memrd_a), .idExRt(exrt_a), .idJump(jmp_a), .memBranchTaken(br_a),
    .outStall(stall_a), .pcWrite(pcw_a), .ifIdWrite(ifidw_a), .ifIdFlush(iff_a),
    .idExFlush(idf_a), .exMemFlush(exf_a), .stallCycles(scnt_a), .flushEvents(fcnt_a)
  );

  hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .COUNT_W(2)) u_b (
    .clk(clk), .reset(reset_b), .idOpcode(op_b), .idRs(rs_b), .idRt(rt_b),
    .idExMemRead(memrd_b), .idExRt(exrt_b), .idJump(jmp_b), .memBranchTaken(br_b),
    .outStall(stall_b), .pcWrite(pcw_b), .ifIdWrite(ifidw_b), .ifIdFlush(iff_b),
    .idExFlush(idf_b), .exMemFlush(exf_b), .stallCycles(scnt_b), .flushEvents(fcnt_b)
  );

  // Control vector order: outStall pcWrite ifIdWrite ifIdFlush idExFlush exMemFlush
  localparam logic [5:0] C_DEF   = 6'b111000;
  localparam logic [5:0] C_STALL = 6'b000000;
  localparam logic [5:0] C_BR    = 6'b111111;
  localparam logic [5:0] C_JMP   = 6'b111100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive_a(input logic rst, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic memrd, input logic [4:0] exrt,
                         input logic jmp, input logic br);
    @(negedge clk);
    reset_a = rst; op_a = op; rs_a = rs; rt_a = rt;
    memrd_a = memrd; exrt_a = exrt; jmp_a = jmp; br_a = br;
    #1;
  endtask

  task automatic drive_b(input logic rst, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic memrd, input logic [4:0] exrt,
                         input logic jmp, input logic br);
    @(negedge clk);
    reset_b = rst; op_b = op; rs_b = rs; rt_b = rt;
    memrd_b = memrd; exrt_b = exrt; jmp_b = jmp; br_b = br;
    #1;
  endtask

  function automatic logic [31:0] ctl_a();
    return {26'd0, stall_a, pcw_a, ifidw_a, iff_a, idf_a, exf_a};
  endfunction

  function automatic logic [31:0] ctl_b();
    return {26'd0, stall_b, pcw_b, ifidw_b, iff_b, idf_b, exf_b};
  endfunction

  initial begin
    reset_a = 1'b1; op_a = '0; rs_a = '0; rt_a = '0; memrd_a = 1'b0; exrt_a = '0; jmp_a = 1'b0; br_a = 1'b0;
    reset_b = 1'b1; op_b = '0; rs_b = '0; rt_b = '0; memrd_b = 1'b0; exrt_b = '0; jmp_b = 1'b0; br_b = 1'b0;

    // ---------------- Instance A ----------------
    // Hazard inputs present during reset: detection suppressed.
    drive_a(1'b1, 6'd35, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1);
    chk("a_reset_ctl", ctl_a(), C_DEF);
    drive_a(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("a_reset_ctl_idle", ctl_a(), C_DEF);
    chk("a_reset_scnt", scnt_a, 0);
    chk("a_reset_fcnt", fcnt_a, 0);

    // T1: load-use via rs.
    drive_a(1'b0, 6'd35, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
    chk("t1_stall", ctl_a(), C_STALL);
    drive_a(1'b0, 6'd35, 5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
    chk("t1_release", ctl_a(), C_DEF);
    chk("t1_scnt", scnt_a, 1);

    // T2: rt only counts for opcodes that read rt.
    drive_a(1'b0, 6'd0, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
    chk("t2_rtype_rt", ctl_a(), C_STALL);
    drive_a(1'b0, 6'd8, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
    chk("t2_addi_rt", ctl_a(), C_DEF);
    drive_a(1'b0, 6'd43, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
    chk("t2_sw_rt", ctl_a(), C_STALL);
    drive_a(1'b0, 6'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("t2_r0", ctl_a(), C_DEF);
    drive_a(1'b0, 6'd0, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0);
    chk("t2_no_memread", ctl_a(), C_DEF);
    chk("t2_scnt", scnt_a, 3);

    // T3: taken branch beats load-use and jump.
    drive_a(1'b0, 6'd35, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1);
    chk("t3_branch", ctl_a(), C_BR);
    drive_a(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t3_fcnt", fcnt_a, 1);
    chk("t3_scnt", scnt_a, 3);

    // T5: jump alone flushes IF/ID only; jump with load-use stalls.
    drive_a(1'b0, 6'd2, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("t5_jump", ctl_a(), C_JMP);
    drive_a(1'b0, 6'd2, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    chk("t5_jump_loaduse", ctl_a(), C_STALL);
    drive_a(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t5_idle", ctl_a(), C_DEF);
    chk("t5_scnt", scnt_a, 4);
    chk("t5_fcnt", fcnt_a, 2);

    // Reset clears counters.
    drive_a(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_a(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("a_rst2_scnt", scnt_a, 0);
    chk("a_rst2_fcnt", fcnt_a, 0);

    // ---------------- Instance B (3 bubbles, 2-bit counters) ----------------
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("b_reset_scnt", scnt_b, 0);

    // T4: single hazard cycle gives exactly three bubbles.
    drive_b(1'b0, 6'd35, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("t4_bubble1", ctl_b(), C_STALL);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t4_bubble2", ctl_b(), C_STALL);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t4_bubble3", ctl_b(), C_STALL);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t4_run", ctl_b(), C_DEF);
    chk("t4_scnt3", scnt_b, 3);

    // T6: three more bubbles; 2-bit counter holds at 3.
    drive_b(1'b0, 6'd35, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t6_sat_ctl", ctl_b(), C_DEF);
    chk("t6_scnt_sat", scnt_b, 3);

    // T4: branch in the second bubble aborts the hold.
    drive_b(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_b(1'b0, 6'd35, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("t4b_bubble1", ctl_b(), C_STALL);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("t4b_branch", ctl_b(), C_BR);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t4b_after", ctl_b(), C_DEF);
    chk("t4b_scnt", scnt_b, 1);
    chk("t4b_fcnt", fcnt_b, 1);

    // Flush counter saturation: four more branch cycles.
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    end
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t6_fcnt_sat", fcnt_b, 3);

    // T6: reset mid-HOLD drops remaining bubbles and clears counters.
    drive_b(1'b0, 6'd35, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("t6_hold_enter", ctl_b(), C_STALL);
    drive_b(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t6_in_reset", ctl_b(), C_DEF);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t6_after_reset", ctl_b(), C_DEF);
    chk("t6_rst_scnt", scnt_b, 0);
    chk("t6_rst_fcnt", fcnt_b, 0);
    drive_b(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t6_still_run", ctl_b(), C_DEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
